// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types for the bit-serial subtractor.
//   - state_t : FSM state encoding (IDLE, RUN, DONE), 2 bits wide.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_if.sv
// ---------------------------------------------------------------------------
// serial_sub_if
//   Operand/result handshake bundle for serial_sub.
//   Signals:
//     in_valid / in_ready   operand pair handshake (producer -> subtractor)
//     a, b                  minuend / subtrahend, WIDTH bits, unsigned
//     out_valid / out_ready result handshake (subtractor -> consumer)
//     diff, borrow          (a - b) mod 2**WIDTH, and 1 iff a < b
//   Modports:
//     master : the environment (drives operands, accepts results)
//     slave  : the subtractor
// ---------------------------------------------------------------------------
interface serial_sub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    input  out_valid,
    output out_ready,
    input  diff,
    input  borrow
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    output out_valid,
    input  out_ready,
    output diff,
    output borrow
  );

endinterface : serial_sub_if

// File: rtl/serial_sub_full_sub_cell.sv
// ---------------------------------------------------------------------------
// full_sub_cell
//   Combinational 1-bit full subtractor: computes i_a - i_b - i_bin.
//   Ports:
//     i_a    in  1  minuend bit
//     i_b    in  1  subtrahend bit
//     i_bin  in  1  borrow in from the less significant bit
//     o_d    out 1  difference bit
//     o_bout out 1  borrow out to the more significant bit
// ---------------------------------------------------------------------------
module full_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule : full_sub_cell

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial unsigned subtractor: diff = a - b, borrow = (a < b).
//   One operand pair is accepted per transaction, processed LSB first at one
//   bit per clock through a single borrow flop, and the result is presented
//   until the consumer takes it. No overlap between transactions.
//   Parameters:
//     WIDTH  operand/result width in bits (>= 1)
//   Ports:
//     clk    in  1  rising-edge clock
//     rst_n  in  1  asynchronous active-low reset
//     bus    slave modport of serial_sub_if (operand and result handshakes)
//   All bus outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;

  // The single subtractor cell works on the current LSBs of the shifters.
  full_sub_cell u_cell (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_bw),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // The minuend register doubles as the result register: as it shifts right,
  // each difference bit enters at the vacated MSB, so after WIDTH shifts it
  // holds the full difference with bit 0 in position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_d;
      assign w_b_next = 1'b0;
    end else begin : g_wn
      assign w_a_next = {w_d,  r_a_sh[WIDTH-1:1]};
      assign w_b_next = {1'b0, r_b_sh[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_bw        <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_bw       <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        RUN: begin
          r_a_sh <= w_a_next;
          r_b_sh <= w_b_next;
          r_bw   <= w_bout;
          r_cnt  <= r_cnt + CW'(1);
          // Last bit: capture the result on the same edge the state changes,
          // so out_valid rises exactly WIDTH edges after acceptance.
          if (r_cnt == LAST) begin
            r_diff      <= w_a_next;
            r_borrow    <= w_bout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= RUN;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
//   Self-checking bench for serial_sub at WIDTH=8 and WIDTH=1. Expected
//   results come from plain arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_sub;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(1)) bus1 ();

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 transaction with `hold` cycles of back-pressure in DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] exp_d;
    logic       exp_b;
    int         n;
    exp_d = a - b;
    exp_b = (a < b) ? 1'b1 : 1'b0;
    bus8.a         = a;
    bus8.b         = b;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b0;
    check("in_ready_idle", 32'(bus8.in_ready), 32'd1);
    step();
    bus8.in_valid = 1'b0;
    bus8.a        = ~a;
    bus8.b        = ~b;
    n = 0;
    while (bus8.out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("latency8", 32'(n), 32'd8);
    check("diff8", 32'(bus8.diff), 32'(exp_d));
    check("borrow8", 32'(bus8.borrow), 32'(exp_b));
    for (int i = 0; i < hold; i++) begin
      bus8.in_valid = i[0];
      step();
      check("hold_valid", 32'(bus8.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus8.in_ready), 32'd0);
      check("hold_diff", 32'(bus8.diff), 32'(exp_d));
      check("hold_borrow", 32'(bus8.borrow), 32'(exp_b));
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check("release_valid", 32'(bus8.out_valid), 32'd0);
    check("release_in_ready", 32'(bus8.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  sd;
    logic        sb;
    logic        acc;
    logic        ohs;
    int          pushed;
    int          popped;
    int          cyc;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'd0);
    check("rst_borrow", 32'(bus8.borrow), 32'd0);
    check("rst_in_ready_w1", 32'(bus1.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Directed transactions, including boundary values
    run8(8'h5A, 8'h23, 0);
    run8(8'h00, 8'h01, 0);
    run8(8'hFF, 8'hFF, 0);
    run8(8'h00, 8'hFF, 0);
    run8(8'hFF, 8'h00, 0);

    // Back-pressure in DONE with in_valid pulses
    run8(8'hC3, 8'h3C, 5);

    // Reset three cycles into RUN aborts the transaction
    bus8.a = 8'h77; bus8.b = 8'h11; bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_diff", 32'(bus8.diff), 32'd0);
    check("abort_borrow", 32'(bus8.borrow), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("abort_no_result", 32'(bus8.out_valid), 32'd0);
    run8(8'h10, 8'h01, 0);

    // Back-to-back random stream with random consumer stalls
    pushed = 0;
    popped = 0;
    cyc    = 0;
    bus8.a = 8'($urandom());
    bus8.b = 8'($urandom());
    bus8.in_valid = 1'b1;
    while (popped < 100 && cyc < 20000) begin
      bus8.out_ready = 1'($urandom_range(0, 1));
      acc = bus8.in_valid & bus8.in_ready;
      ohs = bus8.out_valid & bus8.out_ready;
      sd  = bus8.diff;
      sb  = bus8.borrow;
      step();
      cyc++;
      if (acc) begin
        qa.push_back(bus8.a);
        qb.push_back(bus8.b);
        pushed++;
        bus8.a = 8'($urandom());
        bus8.b = 8'($urandom());
        if (pushed == 100) bus8.in_valid = 1'b0;
      end
      if (ohs) begin
        if (qa.size() == 0) begin
          check("stream_spurious", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          check("stream_diff", 32'(sd), 32'(8'(ea - eb)));
          check("stream_borrow", 32'(sb), (ea < eb) ? 32'd1 : 32'd0);
        end
        popped++;
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    check("stream_count", 32'(popped), 32'd100);
    check("stream_pushed", 32'(pushed), 32'd100);
    check("stream_leftover", 32'(qa.size()), 32'd0);

    // WIDTH=1 sweep: one RUN edge per transaction
    for (int p = 0; p < 4; p++) begin
      logic pa;
      logic pb;
      pa = p[1];
      pb = p[0];
      bus1.a = pa; bus1.b = pb; bus1.in_valid = 1'b1;
      check("w1_in_ready", 32'(bus1.in_ready), 32'd1);
      step();
      bus1.in_valid = 1'b0;
      check("w1_not_yet", 32'(bus1.out_valid), 32'd0);
      step();
      check("w1_latency", 32'(bus1.out_valid), 32'd1);
      check("w1_diff", 32'(bus1.diff), 32'(pa ^ pb));
      check("w1_borrow", 32'(bus1.borrow), (pa < pb) ? 32'd1 : 32'd0);
      bus1.out_ready = 1'b1;
      step();
      bus1.out_ready = 1'b0;
      check("w1_release", 32'(bus1.out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_sub
